// File: rtl/forward_ctrl.sv
// -----------------------------------------------------------------------------
// forward_ctrl
//   Forwarding and load-use hazard controller for a 4-stage ID->EX->MEM->WB
//   pipeline. It tracks the destination tags of the instructions in EX (t1)
//   and MEM (t2). For each EX operand it produces a registered mux select:
//   00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
//   A load in EX that feeds the instruction in ID stalls ID for one cycle.
//   Each such stall is counted in a saturating counter.
//
// Parameters
//   RA_W   register address width
//   CNT_W  load-use stall counter width
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs_a/id_use_a  operand A source register / operand A reads a register
//   id_rs_b/id_use_b  operand B source register / operand B reads a register
//   id_rd/id_we       ID destination register / ID instruction writes it
//   id_load           ID instruction is a memory load
//   hold              freeze all state (memory wait)
//   flush             kill the ID instruction (taken branch)
//   stall             freeze PC/IF/ID this cycle (combinational)
//   sel_a/sel_b       forwarding selects for the EX operand muxes (registered)
//   ex_valid          EX holds a real instruction (registered)
//   lu_stall_cnt      saturating count of load-use stalls
// -----------------------------------------------------------------------------
module forward_ctrl #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs_a,
    input  logic             id_use_a,
    input  logic [RA_W-1:0]  id_rs_b,
    input  logic             id_use_b,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_we,
    input  logic             id_load,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             ex_valid,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    // EX-stage tag
    logic            t1_v_q,  t1_v_d;
    logic [RA_W-1:0] t1_rd_q, t1_rd_d;
    logic            t1_we_q, t1_we_d;
    logic            t1_ld_q, t1_ld_d;
    // MEM-stage tag. Whether it was a load no longer matters: its result is
    // available on the MEM/WB path either way.
    logic            t2_v_q,  t2_v_d;
    logic [RA_W-1:0] t2_rd_q, t2_rd_d;
    logic            t2_we_q, t2_we_d;

    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-operand hit against EX (match1) and MEM (match2), plus the select
    // the operand would get if the ID instruction issues this cycle.
    logic [1:0]      match1;
    logic [1:0]      match2;
    logic [1:0][1:0] op_sel;
    logic            issue;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [RA_W-1:0] rs;
            logic            use_r;
            assign rs    = (gi == 0) ? id_rs_a  : id_rs_b;
            assign use_r = (gi == 0) ? id_use_a : id_use_b;
            assign match1[gi] = t1_v_q & t1_we_q & (t1_rd_q == rs) & use_r;
            assign match2[gi] = t2_v_q & t2_we_q & (t2_rd_q == rs) & use_r;
            // A load in EX has no result yet, so it never forwards from EX.
            // That case stalls instead and resolves through MEM next cycle.
            assign op_sel[gi] = (match1[gi] & ~t1_ld_q) ? 2'b10 :
                                match2[gi]              ? 2'b01 : 2'b00;
        end
    endgenerate

    // flush takes priority over a load-use stall
    assign stall = id_valid & ~flush & (|match1) & t1_ld_q;
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        // defaults: everything holds
        t1_v_d     = t1_v_q;
        t1_rd_d    = t1_rd_q;
        t1_we_d    = t1_we_q;
        t1_ld_d    = t1_ld_q;
        t2_v_d     = t2_v_q;
        t2_rd_d    = t2_rd_q;
        t2_we_d    = t2_we_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        ex_valid_d = ex_valid_q;
        cnt_d      = cnt_q;
        if (!hold) begin
            t2_v_d  = t1_v_q;
            t2_rd_d = t1_rd_q;
            t2_we_d = t1_we_q;
            if (issue) begin
                t1_v_d     = 1'b1;
                t1_rd_d    = id_rd;
                t1_we_d    = id_we;
                t1_ld_d    = id_load;
                sel_a_d    = op_sel[0];
                sel_b_d    = op_sel[1];
                ex_valid_d = 1'b1;
            end else begin
                // bubble into EX
                t1_v_d     = 1'b0;
                sel_a_d    = 2'b00;
                sel_b_d    = 2'b00;
                ex_valid_d = 1'b0;
            end
            // a stall that was held counts once, on the releasing edge
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_v_q     <= 1'b0;
            t1_rd_q    <= '0;
            t1_we_q    <= 1'b0;
            t1_ld_q    <= 1'b0;
            t2_v_q     <= 1'b0;
            t2_rd_q    <= '0;
            t2_we_q    <= 1'b0;
            sel_a_q    <= 2'b00;
            sel_b_q    <= 2'b00;
            ex_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            t1_v_q     <= t1_v_d;
            t1_rd_q    <= t1_rd_d;
            t1_we_q    <= t1_we_d;
            t1_ld_q    <= t1_ld_d;
            t2_v_q     <= t2_v_d;
            t2_rd_q    <= t2_rd_d;
            t2_we_q    <= t2_we_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            ex_valid_q <= ex_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign sel_a        = sel_a_q;
    assign sel_b        = sel_b_q;
    assign ex_valid     = ex_valid_q;
    assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
`timescale 1ns/1ps
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_a, id_use_b, id_we, id_load, hold, flush;
    logic [2:0] id_rs_a, id_rs_b, id_rd;
    logic       stall, stall2;
    logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
    logic       ex_valid, ex_valid2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    forward_ctrl #(.RA_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_a(id_rs_a), .id_use_a(id_use_a), .id_rs_b(id_rs_b), .id_use_b(id_use_b),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .hold(hold), .flush(flush),
        .stall(stall), .sel_a(sel_a), .sel_b(sel_b), .ex_valid(ex_valid),
        .lu_stall_cnt(cnt)
    );

    // narrow-counter copy sharing the same stimulus, for saturation
    forward_ctrl #(.RA_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_a(id_rs_a), .id_use_a(id_use_a), .id_rs_b(id_rs_b), .id_use_b(id_use_b),
        .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .hold(hold), .flush(flush),
        .stall(stall2), .sel_a(sel_a2), .sel_b(sel_b2), .ex_valid(ex_valid2),
        .lu_stall_cnt(cnt2)
    );

    typedef struct {
        logic       v;
        logic [2:0] ra;
        logic       ua;
        logic [2:0] rb;
        logic       ub;
        logic [2:0] rd;
        logic       we;
        logic       ld;
        logic       hold;
        logic       flush;
        logic       e_stall;
        logic [1:0] e_sa;
        logic [1:0] e_sb;
        logic       e_exv;
        int         e_cnt;
    } vec_t;

    function automatic vec_t mk(logic v, logic [2:0] ra, logic ua, logic [2:0] rb, logic ub,
                                logic [2:0] rd, logic we, logic ld, logic h, logic f,
                                logic es, logic [1:0] esa, logic [1:0] esb, logic eexv, int ecnt);
        vec_t r;
        r.v = v; r.ra = ra; r.ua = ua; r.rb = rb; r.ub = ub; r.rd = rd; r.we = we; r.ld = ld;
        r.hold = h; r.flush = f; r.e_stall = es; r.e_sa = esa; r.e_sb = esb;
        r.e_exv = eexv; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply one ID-stage record: check stall before the edge, registered outputs after it.
    task automatic step(input string tag, input vec_t t);
        int ecnt2;
        id_valid = t.v; id_rs_a = t.ra; id_use_a = t.ua; id_rs_b = t.rb; id_use_b = t.ub;
        id_rd = t.rd; id_we = t.we; id_load = t.ld; hold = t.hold; flush = t.flush;
        #1;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, t.e_stall});
        @(posedge clk);
        #1;
        ecnt2 = (t.e_cnt > 3) ? 3 : t.e_cnt;
        chk({tag, ".sel_a"}, {30'd0, sel_a}, {30'd0, t.e_sa});
        chk({tag, ".sel_b"}, {30'd0, sel_b}, {30'd0, t.e_sb});
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, t.e_exv});
        chk({tag, ".cnt"}, {16'd0, cnt}, t.e_cnt);
        chk({tag, ".cnt2"}, {30'd0, cnt2}, ecnt2);
        $display("[TB] %s: stall=%0b sel_a=%b sel_b=%b ex_valid=%0b cnt=%0d cnt2=%0d",
                 tag, t.e_stall, sel_a, sel_b, ex_valid, cnt, cnt2);
    endtask

    vec_t vecs[25];

    initial begin
        //            v  ra ua rb ub rd we ld h  f   stall sa     sb     exv cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0); // write r1
        vecs[1]  = mk(1, 1, 1, 5, 1, 2, 1, 0, 0, 0,  0, 2'b10, 2'b00, 1, 0); // read r1 on A, write r2
        vecs[2]  = mk(1, 0, 0, 0, 0, 7, 0, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0); // non-writer gap
        vecs[3]  = mk(1, 6, 1, 2, 1, 3, 0, 0, 0, 0,  0, 2'b00, 2'b01, 1, 0); // read r2 on B
        vecs[4]  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 0); // load r3
        vecs[5]  = mk(1, 0, 0, 3, 1, 4, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0, 1); // load-use stall
        vecs[6]  = mk(1, 0, 0, 3, 1, 4, 1, 0, 0, 0,  0, 2'b00, 2'b01, 1, 1); // consumer issues
        vecs[7]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 1); // r4 again
        vecs[8]  = mk(1, 4, 1, 4, 1, 5, 0, 0, 0, 0,  0, 2'b10, 2'b10, 1, 1); // EX over MEM
        vecs[9]  = mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 1); // load r6
        vecs[10] = mk(1, 6, 0, 6, 0, 1, 0, 0, 0, 0,  0, 2'b00, 2'b00, 1, 1); // use flags off
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 1); // idle
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 1); // write r0
        vecs[13] = mk(1, 0, 1, 0, 1, 2, 0, 0, 0, 0,  0, 2'b10, 2'b10, 1, 1); // r0 forwards
        vecs[14] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 1); // invalid ID: bubble
        vecs[15] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 1); // load r5
        vecs[16] = mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0,  1, 2'b00, 2'b00, 1, 1); // stall under hold
        vecs[17] = mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0,  1, 2'b00, 2'b00, 1, 1);
        vecs[18] = mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0,  1, 2'b00, 2'b00, 1, 1);
        vecs[19] = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  1, 2'b00, 2'b00, 0, 2); // release: count once
        vecs[20] = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0,  0, 2'b01, 2'b00, 1, 2); // resolves via MEM
        vecs[21] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  0, 2'b00, 2'b00, 1, 2); // load r7
        vecs[22] = mk(1, 6, 1, 7, 1, 0, 1, 0, 0, 1,  0, 2'b00, 2'b00, 0, 2); // flush beats stall
        vecs[23] = mk(1, 0, 0, 0, 0, 3, 1, 0, 1, 0,  0, 2'b00, 2'b00, 0, 2); // hold blocks issue
        vecs[24] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 2'b00, 2'b00, 1, 2); // released issue

        rst_n = 1'b0;
        id_valid = 0; id_rs_a = 0; id_use_a = 0; id_rs_b = 0; id_use_b = 0;
        id_rd = 0; id_we = 0; id_load = 0; hold = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", {31'd0, stall}, 0);
        chk("reset.sel_a", {30'd0, sel_a}, 0);
        chk("reset.sel_b", {30'd0, sel_b}, 0);
        chk("reset.ex_valid", {31'd0, ex_valid}, 0);
        chk("reset.cnt", {16'd0, cnt}, 0);
        $display("[TB] reset: stall=%0b sel_a=%b sel_b=%b ex_valid=%0b cnt=%0d",
                 stall, sel_a, sel_b, ex_valid, cnt);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Five more load-use stalls: main counter 2->7, 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            step($sformatf("sat%0d.load", k),
                 mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2 + k));
            step($sformatf("sat%0d.stall", k),
                 mk(1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 3 + k));
            step($sformatf("sat%0d.issue", k),
                 mk(1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 3 + k));
        end

        // Asynchronous reset between edges with a live stall and non-zero state.
        step("arst.load", mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 7));
        step("arst.use",  mk(1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 8));
        step("arst.res",  mk(1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1, 8));
        step("arst.load2", mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 8));
        id_valid = 1; id_rs_a = 4; id_use_a = 1; id_rs_b = 0; id_use_b = 0;
        id_rd = 5; id_we = 1; id_load = 0; hold = 0; flush = 0;
        #1;
        chk("arst.pre_stall", {31'd0, stall}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.stall", {31'd0, stall}, 0);
        chk("arst.sel_a", {30'd0, sel_a}, 0);
        chk("arst.sel_b", {30'd0, sel_b}, 0);
        chk("arst.ex_valid", {31'd0, ex_valid}, 0);
        chk("arst.cnt", {16'd0, cnt}, 0);
        chk("arst.cnt2", {30'd0, cnt2}, 0);
        $display("[TB] async reset: stall=%0b sel_a=%b sel_b=%b ex_valid=%0b cnt=%0d cnt2=%0d",
                 stall, sel_a, sel_b, ex_valid, cnt, cnt2);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", mk(1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound the whole run in case the clock or a step stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
